// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) with a small byte FIFO in front of the consumer.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX,
  input  logic                          clr_rdy,
  output logic                          rdy,
  output logic [7:0]                    rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          frm_err,
  output logic                          ovr_err,
  output logic                          par_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic          rx_s1_q, rx_s2_q, rx_h_q;
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          par_bad_q, par_bad_d;
  logic          baud_zero;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   cnt_q;
  logic          ovr_q;
  logic          pop, full, wr_en;

  // Preset to idle level so reset never manufactures a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_h_q  <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_h_q  <= rx_s2_q;
    end
  end

  assign baud_zero = (baud_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      push_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      push_q    <= push_d;
      par_bad_q <= par_bad_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_zero ? baud_q : baud_q - CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    par_bad_d = par_bad_q;
    frm_err   = 1'b0;
    par_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = baud_q;
        if (rx_h_q && !rx_s2_q) begin
          state_d   = START;
          baud_d    = HALF;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (baud_zero) begin
          if (rx_s2_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            baud_d  = FULL;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (baud_zero) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          baud_d  = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (baud_zero) begin
          // Even parity: data plus parity bit must XOR to zero.
          par_bad_d = (^shift_q) ^ rx_s2_q;
          baud_d    = FULL;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (baud_zero) begin
          state_d = IDLE;
          if (rx_s2_q) push_d  = !par_bad_q;
          else         frm_err = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_err = par_bad_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push while full is only accepted if a pop frees the head slot the same cycle.
  assign pop   = clr_rdy && (cnt_q != '0);
  assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= push_q && full && !pop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdy      = (cnt_q != '0);
  assign fifo_cnt = cnt_q;
  assign rx_data  = rdy ? mem_q[rd_ptr_q] : 8'h00;
  assign ovr_err  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at a short bit period (BAUD_DIV=16, FIFO_DEPTH=4).
module tb_uart_rx_fifo;
  localparam int BD = 16;
  localparam int FD = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Falling start edge to the clock edge that writes the FIFO.
  localparam int PUSH_DLY = 155 + PAR_BITS * BD;

  logic       clk = 1'b0;
  logic       rst, RX, clr_rdy;
  logic       rdy, frm_err, ovr_err, par_err;
  logic [7:0] rx_data;
  logic [$clog2(FD):0] fifo_cnt;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  int n_chk = 0, n_pass = 0;
  int frm_cnt = 0, ovr_cnt = 0, par_cnt = 0, both_cnt = 0;

  uart_rx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
    .rdy(rdy), .rx_data(rx_data), .fifo_cnt(fifo_cnt),
    .frm_err(frm_err), .ovr_err(ovr_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frm_err) frm_cnt++;
      if (ovr_err) ovr_cnt++;
      if (par_err) par_cnt++;
      if (frm_err && ovr_err) both_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BD) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RX = (^d) ^ par_flip;
    repeat (BD) @(negedge clk);
`endif
    RX = stop_b;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rdy(input string tag);
    int k = 0;
    while (!rdy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rdy, 1);
  endtask

  task automatic pop();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    RX = 1'b1; clr_rdy = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_frm", frm_err, 0);
    chk("rst_ovr", ovr_err, 0);
    chk("rst_par", par_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 'G'
    send_byte(8'h47, 1'b1);
    wait_rdy("t1_rdy");
    chk("t1_data", rx_data, 8'h47);
    chk("t1_cnt", fifo_cnt, 1);
    pop();
    chk("t1_pop_rdy", rdy, 0);
    chk("t1_pop_cnt", fifo_cnt, 0);
    idle(BD);

    // Glitch shorter than half a bit
    RX = 1'b0;
    repeat (5) @(negedge clk);
    idle(4 * BD);
    chk("t2_rdy", rdy, 0);
    chk("t2_frm", frm_cnt, 0);

    // Framing error, then a good 'S'
    send_byte(8'h53, 1'b0);
    idle(2 * BD);
    chk("t3_frm", frm_cnt, 1);
    chk("t3_cnt", fifo_cnt, 0);
    send_byte(8'h53, 1'b1);
    wait_rdy("t3_rdy");
    chk("t3_data", rx_data, 8'h53);
    pop();
    idle(BD);

    // Overflow: five bytes into four slots
    for (int b = 1; b <= 5; b++) begin
      send_byte(8'(b), 1'b1);
      idle(BD);
    end
    chk("t4_ovr", ovr_cnt, 1);
    chk("t4_cnt", fifo_cnt, 4);
    for (int k = 1; k <= 4; k++) begin
      chk("t4_pop_data", rx_data, k);
      pop();
    end
    chk("t4_empty", fifo_cnt, 0);

    // Pop coincident with push at full
    for (int b = 6; b <= 9; b++) begin
      send_byte(8'(b), 1'b1);
      idle(BD);
    end
    chk("t4b_full", fifo_cnt, 4);
    fork
      send_byte(8'h0A, 1'b1);
      begin
        @(negedge clk);
        repeat (PUSH_DLY) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    idle(2 * BD);
    chk("t4b_ovr", ovr_cnt, 1);
    chk("t4b_cnt", fifo_cnt, 4);
    for (int k = 7; k <= 10; k++) begin
      chk("t4b_pop_data", rx_data, k);
      pop();
    end

    // Reset in the middle of data bit 4, with a byte already queued
    send_byte(8'h33, 1'b1);
    wait_rdy("t5_pre_rdy");
    idle(BD);
    v = 8'hA5;
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = v[i];
      repeat (BD) @(negedge clk);
    end
    RX = v[4];
    repeat (BD / 2) @(negedge clk);
    rst = 1'b1;
    RX = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rdy", rdy, 0);
    chk("t5_cnt", fifo_cnt, 0);
    idle(3 * BD);
    chk("t5_idle_rdy", rdy, 0);
    send_byte(8'hA5, 1'b1);
    wait_rdy("t5_rdy2");
    chk("t5_data", rx_data, 8'hA5);
    chk("t5_cnt2", fifo_cnt, 1);
    pop();
    idle(BD);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    send_byte(8'h47, 1'b1);
    wait_rdy("t6_rdy");
    chk("t6_data", rx_data, 8'h47);
    pop();
    idle(BD);
    par_flip = 1'b1;
    send_byte(8'h47, 1'b1);
    idle(2 * BD);
    par_flip = 1'b0;
    chk("t6_par", par_cnt, 1);
    chk("t6_cnt", fifo_cnt, 0);
`else
    chk("par_none", par_cnt, 0);
`endif
    chk("frm_total", frm_cnt, 1);
    chk("frm_ovr_excl", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
